// File: rtl/check_arbiter_pkg.sv
// Shared definitions for the two-requester sentence arbiter in front of the nesting checker.
package check_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  localparam int CHAR_W   = 8;
  localparam int OK_CNT_W = 16;
  localparam int STALL_W  = 16;

  localparam logic [CHAR_W-1:0] TERM_CHAR  = 8'h2E;
  localparam logic [CHAR_W-1:0] SPACE_CHAR = 8'h20;

endpackage

// File: rtl/check_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] request,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (request)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/check_arbiter.sv
// Serialises whole sentences from two requesters into one shared nesting checker.
// Optional stall watchdog enabled by defining CHECK_ARB_TIMEOUT_EN.
module check_arbiter
  import check_arbiter_pkg::*;
#(
  parameter logic [CHAR_W-1:0] TERM      = TERM_CHAR,
  parameter int                MAX_STALL = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s0_valid,
  input  logic [CHAR_W-1:0]   s0_data,
  output logic                s0_ready,
  input  logic                s1_valid,
  input  logic [CHAR_W-1:0]   s1_data,
  output logic                s1_ready,
  output logic                chk_clr,
  output logic                chk_en,
  output logic [CHAR_W-1:0]   chk_char,
  input  logic                chk_result,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_id,
  output logic                resp_result,
  output logic                resp_abort,
  output logic [OK_CNT_W-1:0] ok_cnt
);

  state_e              state_q, state_d;
  logic [1:0]          req, arb_grant;
  logic                grant_id_q, grant_id_d;
  logic                last_q, last_d;
  logic                chk_clr_q, chk_clr_d;
  logic                chk_en_q, chk_en_d;
  logic [CHAR_W-1:0]   chk_char_q, chk_char_d;
  logic                resp_result_q, resp_result_d;
  logic [OK_CNT_W-1:0] ok_cnt_q, ok_cnt_d;
  logic                cur_valid;
  logic [CHAR_W-1:0]   cur_data;
  logic                accept, take_grant, handshake, abort_now;

  assign req = {s1_valid, s0_valid};

  rr_arb2 u_rr_arb2 (
    .request (req),
    .last    (last_q),
    .grant   (arb_grant)
  );

  assign cur_valid  = grant_id_q ? s1_valid : s0_valid;
  assign cur_data   = grant_id_q ? s1_data : s0_data;
  assign accept     = (state_q == ST_STREAM) && cur_valid;
  assign take_grant = (state_q == ST_IDLE) && (|req);
  assign handshake  = (state_q == ST_RESP) && resp_ready;

`ifdef CHECK_ARB_TIMEOUT_EN
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(MAX_STALL - 1);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic               resp_abort_q, resp_abort_d;

  // The cycle that would bring the idle count up to MAX_STALL aborts the sentence.
  assign abort_now = (state_q == ST_STREAM) && !cur_valid && (stall_q == STALL_LAST);

  always_comb begin
    stall_d      = stall_q;
    resp_abort_d = resp_abort_q;
    if (take_grant) begin
      stall_d      = '0;
      resp_abort_d = 1'b0;
    end else if (state_q == ST_STREAM) begin
      stall_d = cur_valid ? '0 : stall_q + 1'b1;
      if (abort_now) resp_abort_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q      <= '0;
      resp_abort_q <= 1'b0;
    end else begin
      stall_q      <= stall_d;
      resp_abort_q <= resp_abort_d;
    end
  end

  assign resp_abort = resp_abort_q;
`else
  assign abort_now  = 1'b0;
  assign resp_abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (|req) state_d = ST_CLR;
      ST_CLR:    state_d = ST_STREAM;
      ST_STREAM: begin
        if (accept && (cur_data == TERM)) state_d = ST_FLUSH;
        else if (abort_now)               state_d = ST_RESP;
      end
      ST_FLUSH:  state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = ST_RESP;
      ST_RESP:   if (resp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // The terminator itself is never forwarded; a space closes the last word instead.
  always_comb begin
    s0_ready      = (state_q == ST_STREAM) && !grant_id_q;
    s1_ready      = (state_q == ST_STREAM) && grant_id_q;
    resp_valid    = (state_q == ST_RESP);
    chk_clr_d     = take_grant;
    chk_en_d      = accept;
    chk_char_d    = '0;
    if (accept) chk_char_d = (cur_data == TERM) ? SPACE_CHAR : cur_data;
    grant_id_d    = take_grant ? arb_grant[1] : grant_id_q;
    resp_result_d = resp_result_q;
    if (take_grant || abort_now)   resp_result_d = 1'b0;
    else if (state_q == ST_SAMPLE) resp_result_d = chk_result;
    ok_cnt_d      = (handshake && resp_result_q) ? ok_cnt_q + 1'b1 : ok_cnt_q;
    last_d        = handshake ? grant_id_q : last_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id_q    <= 1'b0;
      last_q        <= 1'b1;
      chk_clr_q     <= 1'b0;
      chk_en_q      <= 1'b0;
      chk_char_q    <= '0;
      resp_result_q <= 1'b0;
      ok_cnt_q      <= '0;
    end else begin
      grant_id_q    <= grant_id_d;
      last_q        <= last_d;
      chk_clr_q     <= chk_clr_d;
      chk_en_q      <= chk_en_d;
      chk_char_q    <= chk_char_d;
      resp_result_q <= resp_result_d;
      ok_cnt_q      <= ok_cnt_d;
    end
  end

  assign chk_clr     = chk_clr_q;
  assign chk_en      = chk_en_q;
  assign chk_char    = chk_char_q;
  assign resp_id     = grant_id_q;
  assign resp_result = resp_result_q;
  assign ok_cnt      = ok_cnt_q;

endmodule

// File: tb/tb_check_arbiter.sv
// Bench for check_arbiter: emulates the begin/end nesting checker and scores sentences.
module tb_check_arbiter;

`ifdef CHECK_ARB_TIMEOUT_EN
  localparam int TB_MAX_STALL = 4;
`else
  localparam int TB_MAX_STALL = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        s0_valid, s1_valid, s0_ready, s1_ready;
  logic [7:0]  s0_data, s1_data;
  logic        chk_clr, chk_en, chk_result;
  logic [7:0]  chk_char;
  logic        resp_valid, resp_ready, resp_id, resp_result, resp_abort;
  logic [15:0] ok_cnt;

  always #5 clk = ~clk;

  check_arbiter #(.TERM(8'h2E), .MAX_STALL(TB_MAX_STALL)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .chk_clr(chk_clr), .chk_en(chk_en), .chk_char(chk_char), .chk_result(chk_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_abort(resp_abort), .ok_cnt(ok_cnt)
  );

  // External checker: "begin" opens, "end" closes, any other non-empty word is an error.
  localparam logic [39:0] W_BEGIN = "begin";
  localparam logic [23:0] W_END   = "end";
  logic [63:0] w_q;
  int          wlen_q, depth_q;
  bit          err_q;

  always @(posedge clk or posedge reset) begin
    if (reset || chk_clr) begin
      w_q <= '0; wlen_q <= 0; depth_q <= 0; err_q <= 1'b0;
    end else if (chk_en) begin
      if (chk_char == 8'h20) begin
        if (wlen_q == 0) ;
        else if (wlen_q == 5 && w_q[39:0] == W_BEGIN) depth_q <= depth_q + 1;
        else if (wlen_q == 3 && w_q[23:0] == W_END) begin
          if (depth_q == 0) err_q <= 1'b1;
          else depth_q <= depth_q - 1;
        end else err_q <= 1'b1;
        w_q <= '0; wlen_q <= 0;
      end else begin
        w_q <= {w_q[55:0], chk_char};
        wlen_q <= wlen_q + 1;
      end
    end
  end
  assign chk_result = !err_q && (depth_q == 0);

  typedef struct packed { logic id; logic result; logic abort; } resp_t;
  typedef struct { bit id; string text; int gap_at; int gap_n; string exp_chars; bit exp_result; } vec_t;

  resp_t      resp_q[$];
  byte        chk_q[$];
  int         clr_cnt = 0;
  int         both_rdy_cnt = 0;
  int         n_cmp = 0, n_bad = 0;
  int         exp_ok = 0;
  vec_t       tbl[$];

  always @(negedge clk) begin
    if (chk_en) chk_q.push_back(chk_char);
    if (chk_clr) clr_cnt++;
    if (s0_ready && s1_ready) both_rdy_cnt++;
    if (resp_valid && resp_ready) resp_q.push_back('{resp_id, resp_result, resp_abort});
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_str(input string nm, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
    end
  endtask

  function automatic string chk_log();
    string s = "";
    foreach (chk_q[i]) s = $sformatf("%s%c", s, chk_q[i]);
    return s;
  endfunction

  // Reference verdict straight from the sentence text (terminator already stripped).
  function automatic bit ref_bal(input string s);
    int depth = 0;
    bit err = 0;
    string w = "";
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s[i] == " ") begin
        if (w == "begin") depth++;
        else if (w == "end") begin
          if (depth == 0) err = 1; else depth--;
        end else if (w != "") err = 1;
        w = "";
      end else w = {w, s.substr(i, i)};
    end
    return !err && depth == 0;
  endfunction

  function automatic logic [31:0] all_outs();
    return {s0_ready, s1_ready, chk_clr, chk_en, chk_char, resp_valid, resp_id,
            resp_result, resp_abort, ok_cnt};
  endfunction

  task automatic drive(input bit id, input logic v, input logic [7:0] d);
    if (id) begin s1_valid = v; s1_data = d; end
    else    begin s0_valid = v; s0_data = d; end
  endtask

  task automatic send(input bit id, input string s, input int gap_at, input int gap_n, input bit rgap);
    for (int i = 0; i < s.len(); i++) begin
      int g = (i == gap_at) ? gap_n : (rgap ? int'($urandom_range(0, 2)) : 0);
      int w = 0;
      drive(id, 1'b0, 8'h00);
      repeat (g) @(negedge clk);
      drive(id, 1'b1, s[i]);
      while (!(id ? s1_ready : s0_ready)) begin
        @(negedge clk);
        w++;
        if (w > 400) begin
          check("ready_timeout", 32'(w), 0);
          drive(id, 1'b0, 8'h00);
          return;
        end
      end
      @(negedge clk);
    end
    drive(id, 1'b0, 8'h00);
  endtask

  task automatic wait_resp(output resp_t r);
    r = '0;
    for (int i = 0; i < 300; i++) begin
      if (resp_q.size() > 0) begin
        r = resp_q.pop_front();
        return;
      end
      @(negedge clk);
      #1;
    end
    check("resp_timeout", 1, 0);
  endtask

  task automatic run_sentence(input bit id, input string s, input int gap_at, input int gap_n,
                              input bit rgap, input int rdly, input string exp_chars, input bit exp_res);
    resp_t r;
    chk_q.delete();
    clr_cnt = 0;
    resp_ready = (rdly == 0);
    send(id, s, gap_at, gap_n, rgap);
    repeat (rdly) @(negedge clk);
    resp_ready = 1'b1;
    wait_resp(r);
    check_str("chars", chk_log(), exp_chars);
    check("clr_pulses", clr_cnt, 1);
    check("resp_id", r.id, id);
    check("resp_result", r.result, exp_res);
    check("resp_abort", r.abort, 0);
    if (exp_res) exp_ok++;
    @(negedge clk);
    check("ok_cnt", ok_cnt, exp_ok[15:0]);
  endtask

  task automatic add_vec(input bit id, input string t, input int ga, input int gn, input string ec, input bit er);
    vec_t v;
    v.id = id; v.text = t; v.gap_at = ga; v.gap_n = gn; v.exp_chars = ec; v.exp_result = er;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resp_t r;
    int    bad;
    logic  h_id, h_res, h_abt;

    add_vec(0, "begin end.", -1, 0, "begin end ", 1);
    add_vec(0, ".", -1, 0, " ", 1);
    add_vec(1, "beg in.", 2, 3, "beg in ", 0);
    add_vec(1, "end.", -1, 0, "end ", 0);
    add_vec(0, "begin begin end end.", -1, 0, "begin begin end end ", 1);
    add_vec(1, "end begin.", 4, 2, "end begin ", 0);
    add_vec(0, "begin.", -1, 0, "begin ", 0);

    reset = 1'b1; resp_ready = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0; s0_data = 8'h00; s1_data = 8'h00;
    #3;
    check("reset_outputs", all_outs(), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    check("after_reset_outputs", all_outs(), 0);

    // Both requesters valid from reset: s0 wins the first tie, s1 follows.
    resp_ready = 1'b1;
    chk_q.delete(); clr_cnt = 0;
    fork
      send(0, "begin end.", -1, 0, 0);
      send(1, "end.", -1, 0, 0);
    join
    wait_resp(r);
    check("tie_first_id", r.id, 0);
    check("tie_first_result", r.result, 1);
    wait_resp(r);
    check("tie_second_id", r.id, 1);
    check("tie_second_result", r.result, 0);
    exp_ok++;
    @(negedge clk);
    check("tie_ok_cnt", ok_cnt, exp_ok[15:0]);
    check_str("tie_chars", chk_log(), "begin end end ");
    check("tie_clr_pulses", clr_cnt, 2);

    foreach (tbl[i])
      run_sentence(tbl[i].id, tbl[i].text, tbl[i].gap_at, tbl[i].gap_n, 0, 0,
                   tbl[i].exp_chars, tbl[i].exp_result);

    // Consumer back-pressure with another requester pending.
    resp_ready = 1'b0;
    chk_q.delete();
    fork
      send(0, "begin end.", -1, 0, 0);
      send(1, "end.", 0, 3, 0);
      begin
        int w = 0;
        while (!resp_valid && w < 100) begin @(negedge clk); w++; end
        check("hold_seen", resp_valid, 1);
        h_id = resp_id; h_res = resp_result; h_abt = resp_abort;
        bad = 0;
        repeat (10) begin
          @(negedge clk);
          if (!resp_valid || resp_id !== h_id || resp_result !== h_res ||
              resp_abort !== h_abt || s0_ready || s1_ready) bad++;
        end
        check("hold_stable", bad, 0);
        check("hold_id", h_id, 0);
        check("hold_result", h_res, 1);
        resp_ready = 1'b1;
      end
    join
    wait_resp(r);
    check("bp_first_id", r.id, 0);
    wait_resp(r);
    check("bp_second_id", r.id, 1);
    check("bp_second_result", r.result, 0);
    exp_ok++;
    @(negedge clk);
    check("bp_ok_cnt", ok_cnt, exp_ok[15:0]);
    check_str("bp_chars", chk_log(), "begin end end ");

    // Reset in the middle of a sentence drops it without a response.
    drive(0, 1'b1, "b");
    begin
      int w = 0;
      while (!s0_ready && w < 20) begin @(negedge clk); w++; end
    end
    @(negedge clk);
    drive(0, 1'b1, "e");
    @(negedge clk);
    #2 reset = 1'b1;
    drive(0, 1'b0, 8'h00);
    #1;
    check("midreset_outputs", all_outs(), 0);
    @(negedge clk);
    reset = 1'b0;
    exp_ok = 0;
    resp_q.delete();
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (chk_clr || chk_en || resp_valid || s0_ready || s1_ready) bad++;
    end
    check("midreset_idle", bad, 0);
    check("midreset_no_resp", resp_q.size(), 0);
    run_sentence(0, ".", -1, 0, 0, 0, " ", 1);

`ifdef CHECK_ARB_TIMEOUT_EN
    begin
      int n = 1;
      chk_q.delete();
      resp_ready = 1'b1;
      send(0, "be", -1, 0, 0);
      while (!resp_valid && n < 12) begin @(negedge clk); n++; end
      check("timeout_latency_ok", (n >= 4 && n <= 6), 1);
      wait_resp(r);
      check("timeout_abort", r.abort, 1);
      check("timeout_result", r.result, 0);
      check_str("timeout_chars", chk_log(), "be");
      @(negedge clk);
      check("timeout_ok_cnt", ok_cnt, exp_ok[15:0]);
      run_sentence(1, "begin end.", -1, 0, 0, 0, "begin end ", 1);
    end
`endif

    // Random sentences against the text-level reference.
    for (int k = 0; k < 24; k++) begin
      string s = "";
      string body, w;
      int nw = $urandom_range(0, 4);
      for (int j = 0; j < nw; j++) begin
        int p = $urandom_range(0, 9);
        w = (p < 5) ? "begin" : (p < 9) ? "end" : "in";
        s = (j == 0) ? w : {s, " ", w};
      end
      body = s;
      s = {s, "."};
      run_sentence(1'($urandom_range(0, 1)), s, -1, 0, 1, $urandom_range(0, 3),
                   {body, " "}, ref_bal(body));
    end

    check("ready_exclusive", both_rdy_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
